// File: rtl/run_seq_pkg.sv
// Shared types and default parameters for the run sequencer.
package run_seq_pkg;

    // Sequencer states; the encoding only needs to be unique.
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CRST,
        S_RUN,
        S_DONE
    } run_state_t;

    localparam int DEF_AW      = 8;
    localparam int DEF_DW      = 8;
    localparam int DEF_CW      = 16;
    localparam int DEF_RST_CYC = 2;
    localparam int DEF_TMO     = 65535;

endpackage

// File: rtl/run_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear, used for the run-cycle count.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         enable,
    output logic [W-1:0] count
);

    // Clear has priority; once all ones the count holds instead of wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/run_sequencer.sv
// Run sequencer: preloads data memory, holds the core in reset, pulses req,
// then counts run cycles until the core reports done or the limit is hit.
// Optional macro RUN_SEQ_STEP_EN adds single-step gating (step in, core_ce out).
module run_sequencer
    import run_seq_pkg::*;
#(
    parameter int AW      = DEF_AW,
    parameter int DW      = DEF_DW,
    parameter int CW      = DEF_CW,
    parameter int RST_CYC = DEF_RST_CYC,
    parameter int TMO     = DEF_TMO
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          load_valid,
    input  logic          load_last,
    input  logic [AW-1:0] load_addr,
    input  logic [DW-1:0] load_data,
    output logic          load_ready,
    output logic          mem_wr_en,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_dat,
    output logic          core_reset,
    output logic          core_req,
    input  logic          core_done,
    output logic          busy,
    output logic          finished,
    output logic          timeout,
    output logic [CW-1:0] cycles
`ifdef RUN_SEQ_STEP_EN
    ,
    input  logic          step,
    output logic          core_ce
`endif
);

    localparam int RCW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

    run_state_t     state;
    run_state_t     state_next;
    logic [RCW-1:0] crst_cnt;
    logic           first_q;
    logic           timeout_q;
    logic           run_ce;
    logic           start_ok;
    logic           load_done;
    logic           crst_done;
    logic           exit_tmo;
    logic [CW:0]    cycles_after;

`ifdef RUN_SEQ_STEP_EN
    // In RUN the core advances only on step pulses; elsewhere it is always enabled.
    always_comb begin
        run_ce = 1'b1;
        if (state == S_RUN) begin
            run_ce = step;
        end
    end

    assign core_ce = run_ce;
`else
    assign run_ce = 1'b1;
`endif

    // Value the cycle count will take at the end of this cycle, for the limit check.
    assign cycles_after = {1'b0, cycles} + {{CW{1'b0}}, run_ce};

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic plus the one-cycle event strobes that drive the side registers.
    always_comb begin
        state_next = state;
        start_ok   = 1'b0;
        load_done  = 1'b0;
        crst_done  = 1'b0;
        exit_tmo   = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_next = S_LOAD;
                    start_ok   = 1'b1;
                end
            end
            S_LOAD: begin
                if (load_valid && load_last) begin
                    state_next = S_CRST;
                    load_done  = 1'b1;
                end
            end
            S_CRST: begin
                if (crst_cnt == '0) begin
                    state_next = S_RUN;
                    crst_done  = 1'b1;
                end
            end
            S_RUN: begin
                if (core_done && !first_q) begin
                    state_next = S_DONE;
                end else if (cycles_after == (CW+1)'(TMO)) begin
                    state_next = S_DONE;
                    exit_tmo   = 1'b1;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Core-reset hold counter: loaded on the last preload word, counts down in CRST.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            crst_cnt <= '0;
        end else if (load_done) begin
            crst_cnt <= RCW'(RST_CYC - 1);
        end else if ((state == S_CRST) && (crst_cnt != '0)) begin
            crst_cnt <= crst_cnt - RCW'(1);
        end
    end

    // Marks the first RUN cycle: drives the req pulse and masks the stale done flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            first_q <= 1'b0;
        end else begin
            first_q <= crst_done;
        end
    end

    // Sticky timeout flag, cleared when a new sequence starts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timeout_q <= 1'b0;
        end else if (start_ok) begin
            timeout_q <= 1'b0;
        end else if (exit_tmo) begin
            timeout_q <= 1'b1;
        end
    end

    // Registered data-memory write port, one cycle behind the accepted preload word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_wr_en <= 1'b0;
            mem_addr  <= '0;
            mem_dat   <= '0;
        end else begin
            mem_wr_en <= (state == S_LOAD) && load_valid;
            if ((state == S_LOAD) && load_valid) begin
                mem_addr <= load_addr;
                mem_dat  <= load_data;
            end
        end
    end

    sat_counter #(
        .W(CW)
    ) u_cycles (
        .clk    (clk),
        .reset  (reset),
        .clear  (start_ok),
        .enable ((state == S_RUN) && run_ce),
        .count  (cycles)
    );

    assign load_ready = (state == S_LOAD);
    assign core_reset = (state != S_RUN);
    assign core_req   = first_q && (state == S_RUN);
    assign busy       = (state == S_LOAD) || (state == S_CRST) || (state == S_RUN);
    assign finished   = (state == S_DONE);
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_run_sequencer.sv
// Self-checking bench for run_sequencer (RST_CYC=2, TMO=20).
// Expected run results come from the rule: a run ends at the first cycle k>=2
// where done is high, or at cycle TMO, whichever comes first.
module tb_run_sequencer;

    localparam int AW      = 8;
    localparam int DW      = 8;
    localparam int CW      = 16;
    localparam int RST_CYC = 2;
    localparam int TMO     = 20;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          load_valid;
    logic          load_last;
    logic [AW-1:0] load_addr;
    logic [DW-1:0] load_data;
    logic          load_ready;
    logic          mem_wr_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_dat;
    logic          core_reset;
    logic          core_req;
    logic          core_done;
    logic          busy;
    logic          finished;
    logic          timeout;
    logic [CW-1:0] cycles;
`ifdef RUN_SEQ_STEP_EN
    logic          step;
    logic          core_ce;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] fixed_data [3] = '{8'hA5, 8'h5A, 8'hFF};

    run_sequencer #(
        .AW(AW), .DW(DW), .CW(CW), .RST_CYC(RST_CYC), .TMO(TMO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .load_valid (load_valid),
        .load_last  (load_last),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .load_ready (load_ready),
        .mem_wr_en  (mem_wr_en),
        .mem_addr   (mem_addr),
        .mem_dat    (mem_dat),
        .core_reset (core_reset),
        .core_req   (core_req),
        .core_done  (core_done),
        .busy       (busy),
        .finished   (finished),
        .timeout    (timeout),
        .cycles     (cycles)
`ifdef RUN_SEQ_STEP_EN
        ,
        .step       (step),
        .core_ce    (core_ce)
`endif
    );

    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a sequence and stream n preload words, checking each registered write.
    task automatic load_words(input string name, input int n, input bit fixed);
        logic [7:0] a;
        logic [7:0] dv;
        int gap;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_cmp++;
        if ({load_ready, busy, finished, timeout, cycles} !== {1'b1, 1'b1, 1'b0, 1'b0, 16'd0}) begin
            n_bad++;
            $display("[TB] FAIL %s load_entry: got rdy=%0b busy=%0b fin=%0b to=%0b cyc=%0d expected 1 1 0 0 0",
                     name, load_ready, busy, finished, timeout, cycles);
        end
        for (int i = 0; i < n; i++) begin
            gap = fixed ? 0 : int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                load_last = $urandom_range(0, 1) == 1;
                tick();
                load_last = 1'b0;
                n_cmp++;
                if (mem_wr_en !== 1'b0) begin
                    n_bad++;
                    $display("[TB] FAIL %s idle_write: got wr_en=%0b expected 0", name, mem_wr_en);
                end
            end
            a  = fixed ? 8'(i) : 8'($urandom);
            dv = fixed ? fixed_data[i % 3] : 8'($urandom);
            load_valid = 1'b1;
            load_addr  = a;
            load_data  = dv;
            load_last  = (i == n - 1);
            tick();
            load_valid = 1'b0;
            load_last  = 1'b0;
            load_addr  = 8'($urandom);
            load_data  = 8'($urandom);
            n_cmp++;
            if ({mem_wr_en, mem_addr, mem_dat} !== {1'b1, a, dv}) begin
                n_bad++;
                $display("[TB] FAIL %s word%0d: got en=%0b addr=%h dat=%h expected en=1 addr=%h dat=%h",
                         name, i, mem_wr_en, mem_addr, mem_dat, a, dv);
            end
        end
    endtask

    // Count cycles the core stays in reset after the last preload word.
    task automatic crst_phase(input string name);
        int cnt = 0;
        while (core_reset === 1'b1 && cnt < 50) begin
            cnt++;
            tick();
        end
        n_cmp++;
        if (cnt != RST_CYC) begin
            n_bad++;
            $display("[TB] FAIL %s core_reset_len: got %0d expected %0d", name, cnt, RST_CYC);
        end
    endtask

    // Model core: done high at run cycle d (and optionally a stale flag in cycle 1).
    task automatic run_phase(input string name, input int d, input bit stale, input bit rand_start);
        int  k = 1;
        int  reqs = 0;
        bit  seen = 1'b0;
        int  exp_k;
        bit  exp_to;
        logic [CW-1:0] held;
        exp_k  = (d >= 2 && d <= TMO) ? d : TMO;
        exp_to = !(d >= 2 && d <= TMO);
        while (k <= 200) begin
            if (core_req === 1'b1) reqs++;
            core_done = (k == 1 && stale) || (k >= d);
            start = rand_start ? ($urandom_range(0, 1) == 1) : 1'b0;
            tick();
            if (finished === 1'b1) begin
                seen = 1'b1;
                break;
            end
            k++;
        end
        core_done = 1'b0;
        start = 1'b0;
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("[TB] FAIL %s run_bound: got no finish expected finish within 200 cycles", name);
        end
        n_cmp++;
        if (k != exp_k) begin
            n_bad++;
            $display("[TB] FAIL %s run_length: got %0d expected %0d", name, k, exp_k);
        end
        n_cmp++;
        if ({cycles, timeout} !== {16'(exp_k), exp_to}) begin
            n_bad++;
            $display("[TB] FAIL %s result: got cycles=%0d timeout=%0b expected cycles=%0d timeout=%0b",
                     name, cycles, timeout, exp_k, exp_to);
        end
        n_cmp++;
        if (reqs != 1) begin
            n_bad++;
            $display("[TB] FAIL %s req_pulses: got %0d expected 1", name, reqs);
        end
        n_cmp++;
        if ({busy, core_reset, load_ready, core_req} !== 4'b0100) begin
            n_bad++;
            $display("[TB] FAIL %s done_outputs: got busy=%0b crst=%0b rdy=%0b req=%0b expected 0 1 0 0",
                     name, busy, core_reset, load_ready, core_req);
        end
        held = 16'(exp_k);
        repeat (3) tick();
        n_cmp++;
        if ({finished, timeout, cycles} !== {1'b1, exp_to, held}) begin
            n_bad++;
            $display("[TB] FAIL %s done_hold: got fin=%0b to=%0b cyc=%0d expected 1 %0b %0d",
                     name, finished, timeout, cycles, exp_to, held);
        end
    endtask

    task automatic run_case(input string name, input int n, input bit fixed,
                            input int d, input bit stale, input bit rand_start);
        load_words(name, n, fixed);
        crst_phase(name);
        run_phase(name, d, stale, rand_start);
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({load_ready, mem_wr_en, mem_addr, mem_dat, core_reset, core_req, busy, finished, timeout, cycles}
            !== {1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0}) begin
            n_bad++;
            $display("[TB] FAIL reset_values: got rdy=%0b wr=%0b addr=%h dat=%h crst=%0b req=%0b busy=%0b fin=%0b to=%0b cyc=%0d expected 0 0 00 00 1 0 0 0 0 0",
                     load_ready, mem_wr_en, mem_addr, mem_dat, core_reset, core_req, busy, finished, timeout, cycles);
        end
        reset = 1'b0;
        repeat (2) tick();
        n_cmp++;
        if ({load_ready, busy, core_reset} !== 3'b001) begin
            n_bad++;
            $display("[TB] FAIL idle_after_reset: got rdy=%0b busy=%0b crst=%0b expected 0 0 1",
                     load_ready, busy, core_reset);
        end
    endtask

    task automatic test_load_and_run();
        run_case("basic", 3, 1'b1, 11, 1'b0, 1'b0);
    endtask

    task automatic test_timeout();
        run_case("timeout", 2, 1'b0, 1000, 1'b0, 1'b0);
    endtask

    task automatic test_done_at_limit();
        run_case("done_at_limit", 1, 1'b0, TMO, 1'b0, 1'b0);
    endtask

    task automatic test_stale_done();
        run_case("stale_done", 2, 1'b0, 5, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 6; r++) begin
            run_case("random", int'($urandom_range(1, 5)), 1'b0, int'($urandom_range(2, 30)),
                     $urandom_range(0, 1) == 1, 1'b1);
        end
    endtask

    task automatic test_mid_load_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        load_valid = 1'b1;
        load_addr  = 8'h03;
        load_data  = 8'h3C;
        tick();
        n_cmp++;
        if ({mem_wr_en, mem_addr, mem_dat} !== {1'b1, 8'h03, 8'h3C}) begin
            n_bad++;
            $display("[TB] FAIL midreset_word: got en=%0b addr=%h dat=%h expected 1 03 3c",
                     mem_wr_en, mem_addr, mem_dat);
        end
        load_addr = 8'h04;
        load_data = 8'hC3;
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({load_ready, mem_wr_en, mem_addr, mem_dat, core_reset, core_req, busy, finished, timeout, cycles}
            !== {1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0}) begin
            n_bad++;
            $display("[TB] FAIL midreset_values: got rdy=%0b wr=%0b addr=%h dat=%h crst=%0b busy=%0b expected 0 0 00 00 1 0",
                     load_ready, mem_wr_en, mem_addr, mem_dat, core_reset, busy);
        end
        repeat (2) tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if ({mem_wr_en, load_ready, busy} !== 3'b000) begin
                n_bad++;
                $display("[TB] FAIL midreset_nowrite%0d: got wr=%0b rdy=%0b busy=%0b expected 0 0 0",
                         i, mem_wr_en, load_ready, busy);
            end
        end
        load_valid = 1'b0;
        run_case("reload", 3, 1'b1, 7, 1'b0, 1'b0);
    endtask

`ifdef RUN_SEQ_STEP_EN
    // Five step pulses three cycles apart, done raised together with the fifth.
    task automatic test_step();
        int k = 1;
        int pulses = 0;
        bit seen = 1'b0;
        load_words("step", 2, 1'b0);
        n_cmp++;
        if (core_ce !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL step_ce_outside: got %0b expected 1", core_ce);
        end
        step = 1'b0;
        crst_phase("step");
        while (k <= 100) begin
            step = (k >= 2) && ((k - 2) % 3 == 0) && (pulses < 5);
            if (step) pulses++;
            core_done = step && (pulses == 5);
            #1;
            n_cmp++;
            if (core_ce !== step) begin
                n_bad++;
                $display("[TB] FAIL step_ce_k%0d: got %0b expected %0b", k, core_ce, step);
            end
            tick();
            if (finished === 1'b1) begin
                seen = 1'b1;
                break;
            end
            k++;
        end
        step = 1'b1;
        core_done = 1'b0;
        n_cmp++;
        if ({seen, cycles, timeout} !== {1'b1, 16'd5, 1'b0}) begin
            n_bad++;
            $display("[TB] FAIL step_result: got seen=%0b cycles=%0d timeout=%0b expected 1 5 0",
                     seen, cycles, timeout);
        end
        tick();
        n_cmp++;
        if (core_ce !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL step_ce_done: got %0b expected 1", core_ce);
        end
    endtask
`endif

    // Guard against a hung sequence.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no completion expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Scenario sequence.
    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        load_valid = 1'b0;
        load_last  = 1'b0;
        load_addr  = '0;
        load_data  = '0;
        core_done  = 1'b0;
`ifdef RUN_SEQ_STEP_EN
        step       = 1'b1;
`endif
        repeat (2) tick();
        test_reset();
        test_load_and_run();
        test_timeout();
        test_done_at_limit();
        test_stale_done();
        test_back_to_back();
        test_mid_load_reset();
`ifdef RUN_SEQ_STEP_EN
        test_step();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
